// File: rtl/gated_mux2.sv
// Enabled 2:1 mux with a combinational result and a one-cycle registered copy.
// Y follows the inputs directly; Y_q/en_q give synchronous consumers a qualified sample.
module gated_mux2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sel,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_q,
    output logic             en_q
);

    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] r_y_q;
    logic             r_en_q;

    // Nested ternaries so an unknown en or sel shows up as X rather than a default.
    assign w_y = en ? (sel ? D1 : D0) : {WIDTH{1'b0}};
    assign Y   = w_y;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y_q  <= {WIDTH{1'b0}};
            r_en_q <= 1'b0;
        end else begin
            r_y_q  <= w_y;
            r_en_q <= en;
        end
    end

    assign Y_q  = r_y_q;
    assign en_q = r_en_q;

`ifndef SYNTHESIS
    logic [WIDTH-1:0] r_y_prev;
    logic             r_chk_vld;

    always_ff @(posedge clk) begin
        r_y_prev  <= w_y;
        r_chk_vld <= rst_n;
    end

    // Checked at the clock edge so the inputs are stable when sampled.
    always_ff @(posedge clk) begin
        if (!$isunknown({en, sel, D0, D1}))
            assert (Y === (en ? (sel ? D1 : D0) : {WIDTH{1'b0}}))
                else $error("gated_mux2: Y does not match selected source");
        if (r_chk_vld === 1'b1)
            assert (Y_q === r_y_prev)
                else $error("gated_mux2: Y_q does not match previous-cycle Y");
    end
`endif

endmodule

// File: tb/tb_gated_mux2.sv
// Directed bench for gated_mux2: combinational select/enable cases, then the
// registered path through reset hold, release and a mid-operation reset pulse.
module tb_gated_mux2;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             sel;
    logic [WIDTH-1:0] D0;
    logic [WIDTH-1:0] D1;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] Y_q;
    logic             en_q;

    int n_assert = 0;
    int n_fail   = 0;

    gated_mux2 #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .sel  (sel),
        .D0   (D0),
        .D1   (D1),
        .Y    (Y),
        .Y_q  (Y_q),
        .en_q (en_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        sel   = 1'b0;
        D0    = 4'b1010;
        D1    = 4'b0010;

        // Scenario 1-3: enable and select on fixed data
        #4 check("s1_en0_sel0", Y, 4'b0000);
        en = 1'b1; sel = 1'b0;
        #4 check("s2_en1_sel0", Y, 4'b1010);
        en = 1'b0; sel = 1'b1;
        #4 check("s2_en0_sel1", Y, 4'b0000);
        en = 1'b1; sel = 1'b1;
        #4 check("s3_en1_sel1", Y, 4'b0010);

        // Scenario 4: toggling sel, then identical sources
        sel = 1'b0; D0 = 4'b1111; D1 = 4'b0000;
        #4 check("s4_sel0_a", Y, 4'b1111);
        sel = 1'b1;
        #4 check("s4_sel1_a", Y, 4'b0000);
        sel = 1'b0;
        #4 check("s4_sel0_b", Y, 4'b1111);
        sel = 1'b1;
        #4 check("s4_sel1_b", Y, 4'b0000);
        D0 = 4'b0101; D1 = 4'b0101; sel = 1'b0;
        #4 check("s4_eq_sel0", Y, 4'b0101);
        sel = 1'b1;
        #4 check("s4_eq_sel1", Y, 4'b0101);

        // Scenario 5: reset held two cycles, then released
        @(negedge clk);
        rst_n = 1'b0; en = 1'b1; sel = 1'b0; D0 = 4'b1010; D1 = 4'b0010;
        #4 check("s5_y_in_reset", Y, 4'b1010);
        repeat (2) @(posedge clk);
        #1;
        check("s5_yq_reset", Y_q, 4'b0000);
        check("s5_enq_reset", en_q, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("s5_yq_release", Y_q, 4'b1010);
        check("s5_enq_release", en_q, 1'b1);

        // Scenario 6: one-edge reset pulse while selecting D1
        @(negedge clk);
        sel = 1'b1;
        @(posedge clk); #1;
        check("s6_yq_run", Y_q, 4'b0010);
        check("s6_enq_run", en_q, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("s6_yq_reset", Y_q, 4'b0000);
        check("s6_enq_reset", en_q, 1'b0);
        check("s6_y_during_reset", Y, 4'b0010);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("s6_yq_after", Y_q, 4'b0010);
        check("s6_enq_after", en_q, 1'b1);

        // Disable propagates through the register as zero data
        @(negedge clk);
        en = 1'b0;
        #4 check("dis_y", Y, 4'b0000);
        @(posedge clk); #1;
        check("dis_yq", Y_q, 4'b0000);
        check("dis_enq", en_q, 1'b0);

        // Register tracks a new value on D0 one cycle later
        @(negedge clk);
        en = 1'b1; sel = 1'b0; D0 = 4'b0110;
        #1 check("lat_yq_before", Y_q, 4'b0000);
        @(posedge clk); #1;
        check("lat_yq_after", Y_q, 4'b0110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gated_mux2.md
Name: gated_mux2

Overview:
- 2:1 data multiplexer with an output enable, WIDTH bits wide.
- Combinational output Y selects D0 or D1 when enabled and forces zero when disabled.
- A registered copy (Y_q) is provided for downstream synchronous consumers.
- Sits in datapath steering logic between two sources and a single consumer.

Parameters:
- WIDTH, 4, data width of D0, D1, Y, Y_q (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock; used only by the registered outputs.
- rst_n  input  1  synchronous active-low reset; sampled on the rising edge of clk.
- en  input  1  output enable; 0 forces the outputs to zero.
- sel  input  1  select; 0 chooses D0, 1 chooses D1.
- D0  input  WIDTH  data source 0.
- D1  input  WIDTH  data source 1.
- Y  output  WIDTH  combinational mux result.
- Y_q  output  WIDTH  Y registered one cycle.
- en_q  output  1  en registered one cycle; qualifies Y_q.

Behaviour:
- Y is purely combinational: Y = en ? (sel ? D1 : D0) : {WIDTH{1'b0}}.
  - No clock dependency.
  - Settles within the propagation delay of an input change.
  - Y is not affected by rst_n.
- en = 0 dominates sel: Y = 0 for any sel, D0, D1.
- en = 1, sel = 0: Y = D0 exactly, bit for bit.
- en = 1, sel = 1: Y = D1 exactly, bit for bit.
- If D0 == D1, Y is the same for either sel value; no glitch requirement beyond normal combinational settling.
- X or Z on sel with en = 1: Y is X in simulation.
  - The implementation must not mask X with a default branch.
  - Use a ternary or an if/else that propagates X.
- X on en: Y is X in simulation.
- Y_q and en_q registers, on each rising clk edge:
  - rst_n = 0: Y_q <= 0, en_q <= 0.
  - Otherwise: Y_q <= Y, en_q <= en.
- Latency: Y_q and en_q lag the inputs by exactly 1 clock cycle.
- Reset values: Y_q = 0 and en_q = 0 after the first clk edge with rst_n = 0.
  - Y_q and en_q are undefined before any clock edge.
- Reset asserted mid-operation: Y_q and en_q clear on the next clk edge regardless of en, sel or data; Y continues to follow the inputs.
- Reset release: the first edge with rst_n = 1 captures the current Y and en.
- No internal state other than Y_q and en_q; no handshake.
- Include simulation-only assertions:
  - Y equals the reference expression whenever the inputs are known.
  - Y_q equals the previous-cycle Y when rst_n was 1.

Test Plan:
- Bench settles for ≥4 ns after each input change before checking.
- Scenario 1: D0 = 1010, D1 = 0010, en = 0, sel = 0 -> Y = 0000.
- Scenario 2: same data, en = 1, sel = 0 -> Y = 1010; en = 0, sel = 1 -> Y = 0000.
- Scenario 3: same data, en = 1, sel = 1 -> Y = 0010.
- Scenario 4: en = 1, sel = 0, D0 = 1111, D1 = 0000; toggle sel each 4 ns -> Y alternates 1111 / 0000; with D0 = D1 = 0101, Y = 0101 for both sel values.
- Scenario 5 (registered path):
  - Hold rst_n = 0 for 2 cycles with en = 1, sel = 0, D0 = 1010 -> Y = 1010 immediately, Y_q = 0000, en_q = 0.
  - Release rst_n -> Y_q = 1010, en_q = 1 one cycle later.
- Scenario 6 (reset mid-operation): with en = 1, sel = 1, D1 = 0010 running, assert rst_n = 0 for one edge -> Y_q = 0000, en_q = 0 on that edge while Y stays 0010; after deassert, Y_q = 0010 on the next edge.
